bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_adder.sv | 140 ++++++++++++++
 tb/tb_bit_serial_adder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// through a single add cell built from two chained half adders and a carry
// flip-flop. Both sides use a valid/ready handshake, and the cell does not
// overlap one operation with the next.
//
// Optional feature (macro BIT_SERIAL_ADDER_SUB_EN): adds input 'sub'. When
// sub=1 the block computes a - b. In that case cout=1 means there was no
// borrow.
//
// Ports:
//   sys_clk, sys_rst      clock and reset (synchronous, active-high)
//   in_valid / in_ready   operand handshake for a, b, cin (and sub)
//   out_valid / out_ready result handshake for sum, cout
//   busy                  high while an operation is in CALC or DONE
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, sh_s;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             accept_c, last_c;
  logic             p_c, g1_c, g2_c, s_bit_c, carry_nxt_c;
  logic [WIDTH-1:0] sh_s_nxt_c;
  logic [WIDTH-1:0] b_load_c;
  logic             carry_load_c;

  // Operand conditioning at accept: for subtraction, add ~b + 1
`ifdef BIT_SERIAL_ADDER_SUB_EN
  assign b_load_c     = sub ? ~b : b;
  assign carry_load_c = sub ? 1'b1 : cin;
`else
  assign b_load_c     = b;
  assign carry_load_c = cin;
`endif

  // One-bit add cell: two half adders, with their carries ORed
  assign p_c         = sh_a[0] ^ sh_b[0];
  assign g1_c        = sh_a[0] & sh_b[0];
  assign s_bit_c     = p_c ^ carry;
  assign g2_c        = p_c & carry;
  assign carry_nxt_c = g1_c | g2_c;

  // New sum bit enters at the MSB; after WIDTH shifts it lands in bit 0
  assign sh_s_nxt_c = (sh_s >> 1) | (WIDTH'(s_bit_c) << (WIDTH - 1));

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c  = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        last_c = (cnt == CNT_W'(WIDTH - 1));
        if (last_c) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered handshake flags
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sh_a      <= '0;
      sh_b      <= '0;
      sh_s      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      if (accept_c) begin
        sh_a  <= a;
        sh_b  <= b_load_c;
        sh_s  <= '0;
        carry <= carry_load_c;
        cnt   <= '0;
      end else if (state == CALC) begin
        sh_a  <= sh_a >> 1;
        sh_b  <= sh_b >> 1;
        sh_s  <= sh_s_nxt_c;
        carry <= carry_nxt_c;
        cnt   <= cnt + CNT_W'(1);
        // Result is published only on the last bit, so sum stays stable otherwise
        if (last_c) begin
          sum  <= sh_s_nxt_c;
          cout <= carry_nxt_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: directed and random checks of bit_serial_adder at
// WIDTH=8, plus a WIDTH=1 instance for the single-bit case.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic         sub_r = 1'b0;
`endif

  logic w1_in_valid = 1'b0;
  logic w1_in_ready;
  logic w1_a = 1'b0;
  logic w1_b = 1'b0;
  logic w1_cin = 1'b0;
  logic w1_out_valid;
  logic w1_out_ready = 1'b0;
  logic w1_sum;
  logic w1_cout;
  logic w1_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) u_dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .sub       (sub_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  bit_serial_adder #(.WIDTH(1)) u_w1 (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .a         (w1_a),
    .b         (w1_b),
    .cin       (w1_cin),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .sub       (1'b0),
`endif
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .sum       (w1_sum),
    .cout      (w1_cout),
    .busy      (w1_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Wait for in_ready, then present one operand set for exactly one edge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
    check("in_ready_in_calc", 64'(in_ready), 64'(0));
  endtask

`ifdef BIT_SERIAL_ADDER_SUB_EN
  task automatic send_sub(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    sub_r = 1'b1;
    send(ta, tb_v, tc);
    sub_r = 1'b0;
  endtask
`endif

  // Wait for out_valid (latency counted from the accept edge), check, optionally release
  task automatic get_result(input logic [W-1:0] es, input logic ec, input string tag,
                            input bit release_now);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_latency"}, 64'(n), 64'(W));
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    if (release_now) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
      check({tag, "_ready_back"}, 64'(in_ready), 64'(1));
      check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    logic [W:0] exp9;
    logic [W-1:0] ra, rb;
    logic rc;
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_w1_in_ready", 64'(w1_in_ready), 64'(1));
    check("rst_w1_out_valid", 64'(w1_out_valid), 64'(0));
    sys_rst = 1'b0;
    @(posedge clk); #1;

    // Directed sums
    send(8'h0F, 8'h01, 1'b0);
    get_result(8'h10, 1'b0, "0f_01", 1'b1);
    send(8'hFF, 8'h01, 1'b0);
    get_result(8'h00, 1'b1, "ff_01", 1'b1);
    send(8'hFF, 8'hFF, 1'b1);
    get_result(8'hFF, 1'b1, "ff_ff_c", 1'b1);
    send(8'h00, 8'h00, 1'b1);
    get_result(8'h01, 1'b0, "cin_only", 1'b1);

    // Backpressure; operands changed and in_valid held high during CALC/DONE
    send(8'h5A, 8'h33, 1'b0);
    a = 8'h20; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
    get_result(8'h8D, 1'b0, "bp", 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'(1));
      check("bp_hold_sum", 64'(sum), 64'(8'h8D));
      check("bp_hold_cout", 64'(cout), 64'(0));
      check("bp_hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'(1));
    check("bp_release_valid", 64'(out_valid), 64'(0));
    // in_valid still high: the held operands are taken on this edge
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("held_accept_busy", 64'(busy), 64'(1));
    get_result(8'h42, 1'b0, "held", 1'b1);

    // Reset during the fourth CALC cycle aborts the operation
    send(8'h3C, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    sys_rst = 1'b1;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("abort_no_pulse", 64'(seen), 64'(0));
    send(8'h03, 8'h04, 1'b0);
    get_result(8'h07, 1'b0, "after_abort", 1'b1);

    // WIDTH=1: CALC is one edge long
    w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1; w1_in_valid = 1'b1;
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
    check("w1_calc_valid", 64'(w1_out_valid), 64'(0));
    check("w1_calc_busy", 64'(w1_busy), 64'(1));
    @(posedge clk); #1;
    check("w1_valid", 64'(w1_out_valid), 64'(1));
    check("w1_sum", 64'(w1_sum), 64'(1));
    check("w1_cout", 64'(w1_cout), 64'(1));
    w1_out_ready = 1'b1;
    @(posedge clk); #1;
    w1_out_ready = 1'b0;
    check("w1_ready_back", 64'(w1_in_ready), 64'(1));
    w1_a = 1'b1; w1_b = 1'b0; w1_cin = 1'b0; w1_in_valid = 1'b1;
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
    @(posedge clk); #1;
    check("w1b_valid", 64'(w1_out_valid), 64'(1));
    check("w1b_sum", 64'(w1_sum), 64'(1));
    check("w1b_cout", 64'(w1_cout), 64'(0));
    w1_out_ready = 1'b1;
    @(posedge clk); #1;
    w1_out_ready = 1'b0;

`ifdef BIT_SERIAL_ADDER_SUB_EN
    // Subtraction; cin is ignored when sub=1
    send_sub(8'h05, 8'h07, 1'b0);
    get_result(8'hFE, 1'b0, "sub_borrow", 1'b1);
    send_sub(8'h07, 8'h05, 1'b1);
    get_result(8'h02, 1'b1, "sub_noborrow", 1'b1);
`endif

    // Random vectors against a behavioural sum
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      send(ra, rb, rc);
      get_result(exp9[W-1:0], exp9[W], "rnd", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
